button_event_queue: RTL

BUTTON_EVENT_QUEUE -- requirements
Module: button_event_queue

---
 rtl/btn_event_pkg.sv | 22 ++
 rtl/btn_event_fifo.sv | 47 ++++
 rtl/button_event_queue.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/btn_event_pkg.sv
// Shared types for the button event queue: FSM states, event record, hold-counter width.
// The BTN_AUTOREPEAT_EN macro (see button_event_queue) decides whether the repeat path is built.
package btn_event_pkg;

  localparam int unsigned CNT_W = 25;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_REPEAT
  } btn_state_e;

  typedef struct packed {
    logic [2:0] code;
    logic       rep;
  } btn_event_t;

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/btn_event_fifo.sv
// Small event FIFO; a pop frees a slot for a push in the same cycle even when full.
module btn_event_fifo
  import btn_event_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  btn_event_t push_data,
  input  logic       push,
  input  logic       pop,
  output btn_event_t pop_data,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  btn_event_t  mem [DEPTH];
  logic        do_pop;
  logic        do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Head is forced to zero when empty so the outputs read zero out of reset.
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/button_event_queue.sv
// Turns debounced button levels into queued press / auto-repeat events.
// Define BTN_AUTOREPEAT_EN to build the hold counters and repeat events.
module button_event_queue
  import btn_event_pkg::*;
#(
  parameter int unsigned NUM_BTN       = 5,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_filtered,
  output logic               ev_valid,
  input  logic               ev_ready,
  output logic [2:0]         ev_code,
  output logic               ev_repeat,
  output logic               overflow
);

  logic [NUM_BTN-1:0] btn_q;
  logic               btn_q_vld;
  logic [NUM_BTN-1:0] armed;
  logic [NUM_BTN-1:0] press_ev;
  logic [NUM_BTN-1:0] rep_ev;
  logic [NUM_BTN-1:0] pend;
  logic [NUM_BTN-1:0] pend_rep;
  logic [NUM_BTN-1:0] clr_mask;
  btn_state_e         state [NUM_BTN];

  logic       sel_valid;
  logic [2:0] sel_code;
  logic       sel_rep;
  logic       push_ok;
  logic       pop_req;
  logic       fifo_full;
  logic       fifo_empty;
  btn_event_t head;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  logic [CNT_W-1:0] cnt [NUM_BTN];
`else
  assign rep_ev = '0;
`endif

  // A button must be seen released after reset before it can raise a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q     <= '0;
      btn_q_vld <= 1'b0;
      armed     <= '0;
      press_ev  <= '0;
`ifdef BTN_AUTOREPEAT_EN
      rep_ev    <= '0;
`endif
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        state[i] <= ST_IDLE;
`ifdef BTN_AUTOREPEAT_EN
        cnt[i]   <= '0;
`endif
      end
    end else begin
      btn_q     <= btn_filtered;
      btn_q_vld <= 1'b1;
      press_ev  <= '0;
`ifdef BTN_AUTOREPEAT_EN
      rep_ev    <= '0;
`endif
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        if (btn_q_vld && !btn_q[i]) armed[i] <= 1'b1;
        if (!btn_q[i]) begin
          state[i] <= ST_IDLE;
`ifdef BTN_AUTOREPEAT_EN
          cnt[i]   <= '0;
`endif
        end else begin
          case (state[i])
            ST_IDLE: if (armed[i]) begin
              state[i]    <= ST_WAIT;
              press_ev[i] <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
              cnt[i]      <= '0;
`endif
            end
`ifdef BTN_AUTOREPEAT_EN
            ST_WAIT: if (cnt[i] == DELAY_LAST) begin
              state[i]  <= ST_REPEAT;
              rep_ev[i] <= 1'b1;
              cnt[i]    <= '0;
            end else begin
              cnt[i] <= cnt_sat_inc(cnt[i]);
            end
            ST_REPEAT: if (cnt[i] == PERIOD_LAST) begin
              rep_ev[i] <= 1'b1;
              cnt[i]    <= '0;
            end else begin
              cnt[i] <= cnt_sat_inc(cnt[i]);
            end
`else
            ST_WAIT: state[i] <= ST_WAIT;
`endif
            default: state[i] <= ST_IDLE;
          endcase
        end
      end
    end
  end

  assign pop_req = ev_valid && ev_ready;

  always_comb begin
    sel_valid = 1'b0;
    sel_code  = '0;
    sel_rep   = 1'b0;
    clr_mask  = '0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      if (pend[i] && !sel_valid) begin
        sel_valid = 1'b1;
        sel_code  = 3'(i);
        sel_rep   = pend_rep[i];
        clr_mask  = NUM_BTN'(1) << i;
      end
    end
    push_ok = sel_valid && (!fifo_full || pop_req);
    if (!push_ok) clr_mask = '0;
  end

  // A pending bit that is being pushed this cycle is free to take a new event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= '0;
      pend_rep <= '0;
      overflow <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        if (press_ev[i] || rep_ev[i]) begin
          if (pend[i] && !clr_mask[i]) begin
            overflow <= 1'b1;
          end else begin
            pend[i]     <= 1'b1;
            pend_rep[i] <= rep_ev[i];
          end
        end else if (clr_mask[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  btn_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_data ('{code: sel_code, rep: sel_rep}),
    .push      (push_ok),
    .pop       (pop_req),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign ev_valid  = !fifo_empty;
  assign ev_code   = head.code;
  assign ev_repeat = head.rep;

endmodule
